// File: rtl/branch_redirect_unit.sv
// Execute-stage branch/jump resolution with a registered redirect to fetch.
// A taken branch produces a one-cycle REDIRECT, then a one-cycle SQUASH that covers the wrong path.
module branch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_E,
  input  logic                   branch_E,
  input  logic                   jal_E,
  input  logic                   jalr_E,
  input  logic [2:0]             funct3_E,
  input  logic [31:0]            PC_E,
  input  logic [31:0]            imm_E,
  input  logic [31:0]            rs1_E,
  input  logic [31:0]            rs2_E,
  output logic [31:0]            PC_M,
  output logic                   PC_scr,
  output logic                   flush_D,
  output logic                   flush_E,
  output logic                   misalign_M,
  output logic [COUNT_WIDTH-1:0] redirect_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [31:0]            target_m_q;
  logic                   pc_scr_q;
  logic                   flush_d_q;
  logic                   flush_e_q;
  logic                   misalign_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic        cond_s;
  logic        accept_s;
  logic        take_e_s;
  logic [31:0] target_e_s;

  // Branch condition, taken decision and target for the execute-stage instruction.
  always_comb begin
    cond_s = 1'b0;
    case (funct3_E)
      3'b000:  cond_s = (rs1_E == rs2_E);
      3'b001:  cond_s = (rs1_E != rs2_E);
      3'b100:  cond_s = ($signed(rs1_E) <  $signed(rs2_E));
      3'b101:  cond_s = ($signed(rs1_E) >= $signed(rs2_E));
      3'b110:  cond_s = (rs1_E <  rs2_E);
      3'b111:  cond_s = (rs1_E >= rs2_E);
      default: cond_s = 1'b0;
    endcase

    accept_s = (state_q == IDLE);
    take_e_s = valid_E & accept_s & (jal_E | jalr_E | (branch_E & cond_s));

    if (jalr_E) begin
      target_e_s = (rs1_E + imm_E) & 32'hFFFF_FFFE;
    end else begin
      target_e_s = PC_E + imm_E;
    end
  end

  // Redirect sequencer; EX/MEM capture of the taken target happens on the IDLE->REDIRECT edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      target_m_q <= RESET_VECTOR;
      pc_scr_q   <= 1'b1;
      flush_d_q  <= 1'b0;
      flush_e_q  <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (take_e_s) begin
            state_q    <= REDIRECT;
            target_m_q <= target_e_s;
            pc_scr_q   <= 1'b0;
            flush_d_q  <= 1'b1;
            flush_e_q  <= 1'b1;
            if (target_e_s[1]) begin
              misalign_q <= 1'b1;
            end
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
              count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            state_q   <= IDLE;
            pc_scr_q  <= 1'b1;
            flush_d_q <= 1'b0;
            flush_e_q <= 1'b0;
          end
        end
        REDIRECT: begin
          state_q   <= SQUASH;
          pc_scr_q  <= 1'b1;
          flush_d_q <= 1'b1;
          flush_e_q <= 1'b0;
        end
        SQUASH: begin
          state_q   <= IDLE;
          pc_scr_q  <= 1'b1;
          flush_d_q <= 1'b0;
          flush_e_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          pc_scr_q  <= 1'b1;
          flush_d_q <= 1'b0;
          flush_e_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC_M           = target_m_q;
  assign PC_scr         = pc_scr_q;
  assign flush_D        = flush_d_q;
  assign flush_E        = flush_e_q;
  assign misalign_M     = misalign_q;
  assign redirect_count = count_q;

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

- Resolves branches and jumps in the execute stage and registers the result into the memory stage.
- Drives the fetch stage's redirect interface: PC_M is the target PC and PC_scr is the next-PC select, where 1 selects PC+4 and 0 selects PC_M.
- Squashes wrong-path instructions already in flight in decode and execute.
- Keeps a saturating count of taken redirects for performance bring-up.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, value driven on PC_M while in reset.
- COUNT_WIDTH, 16, width of redirect_count.

Ports:
- clock  input  1  rising-edge clock, the single clock of the block.
- reset  input  1  asynchronous, active-high reset.
- valid_E  input  1  the execute-stage instruction is valid (not a bubble).
- branch_E  input  1  the instruction is a conditional branch.
- jal_E  input  1  the instruction is JAL.
- jalr_E  input  1  the instruction is JALR.
- funct3_E  input  3  branch condition code.
- PC_E  input  32  PC of the execute-stage instruction.
- imm_E  input  32  sign-extended immediate.
- rs1_E  input  32  forwarded rs1 value.
- rs2_E  input  32  forwarded rs2 value.
- PC_M  output  32  redirect target presented to fetch.
- PC_scr  output  1  next-PC select: 1 = sequential, 0 = take PC_M.
- flush_D  output  1  squash the instruction entering decode.
- flush_E  output  1  squash the instruction entering execute.
- misalign_M  output  1  sticky flag: a taken target had bit 1 set.
- redirect_count  output  COUNT_WIDTH  saturating count of redirects issued.

## Operation
- Execute-stage evaluation is combinational.
  - funct3 000 BEQ (equal); 001 BNE (not equal); 100 BLT (signed less-than); 101 BGE (signed greater-or-equal); 110 BLTU (unsigned less-than); 111 BGEU (unsigned greater-or-equal).
  - funct3 010 and 011 are never taken.
  - JAL and JALR are always taken.
- Taken condition: take_E = valid_E & accept & (jal_E | jalr_E | (branch_E & cond)).
  - Priority when decode flags overlap: jalr_E > jal_E > branch_E.
- Target arithmetic is 32-bit modulo 2^32; overflow wraps silently.
  - Branch or JAL: PC_E + imm_E.
  - JALR: (rs1_E + imm_E) & 32'hFFFF_FFFE.
- On each clock edge, the EX/MEM registers capture take_E and the target.
- FSM states: IDLE, REDIRECT, SQUASH.
  - IDLE: accept = 1. If take_M is registered, go to REDIRECT.
  - REDIRECT: exactly one cycle. PC_scr = 0, PC_M = registered target, flush_D = 1, flush_E = 1, accept = 0, counter increments. Always goes to SQUASH.
  - SQUASH: exactly one cycle. flush_D = 1 (covers the instruction fetched at the old PC on the redirect edge), accept = 0. Always goes to IDLE.
- When accept = 0, valid_E is ignored; wrong-path branches never redirect.
- In IDLE and SQUASH: PC_scr = 1, and PC_M holds its last value.
- redirect_count saturates at all-ones and never wraps.
- misalign_M is set when a redirect target has bit 1 set. It stays set until reset. The redirect is still issued.

## Timing
- Reset (asynchronous, immediate):
  - PC_M = RESET_VECTOR, PC_scr = 1, flush_D = 0, flush_E = 0, misalign_M = 0, redirect_count = 0.
  - State = IDLE and EX/MEM registers cleared.
- Latency: a taken instruction in E at cycle n gives PC_scr = 0 in cycle n+1, and fetch loads the target at the end of cycle n+1.
- flush_D is high in cycles n+1 and n+2; flush_E is high in cycle n+1 only.
- Back-to-back taken instructions in E at cycles n and n+1: the second is wrong-path and is ignored, producing one redirect.
- A taken instruction in E during SQUASH is ignored. A taken instruction arriving in the first IDLE cycle after SQUASH is accepted.
- Reset asserted during REDIRECT or SQUASH aborts immediately: PC_scr returns to 1 and both flushes drop in the same cycle. No partial count update occurs.
- Outputs are registered or decoded from state only; there is no combinational path from E-stage inputs to outputs.

## Test plan
- Reset mid-run → all outputs at reset values asynchronously, before the next edge. PC_M = 0, PC_scr = 1, redirect_count = 0.
- BEQ, rs1 = rs2 = 5, PC_E = 0x100, imm = 0x20 → next cycle PC_M = 0x120, PC_scr = 0, flush_D = flush_E = 1. Following cycle flush_D only, then idle. Count = 1.
- BLT with rs1 = 0xFFFF_FFFF, rs2 = 1 → taken. Same operands with BLTU → not taken, PC_scr stays 1.
- JALR with rs1 = 0x203, imm = 0 → PC_M = 0x202, misalign_M = 1, and it stays 1.
- Taken JAL in E on two consecutive cycles → exactly one redirect, to the first target. Count increments by 1.
- Preload redirect_count to near-max via 2^COUNT_WIDTH redirects (or COUNT_WIDTH = 2 with 5 redirects) → count holds at 3 and does not wrap.
